writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Final RV32 pipeline stage, directly upstream of the register bank write port.
//  Accepts one retiring instruction per handshake from the memory stage.
//  For loads, waits for the data-memory response, then aligns and sign/zero-extends it.
//  Drives reg_write/rd/rd_value for exactly one cycle per retired write.
//  Flags misaligned or illegal loads and memory timeouts, and counts retired instructions.
// PARAMETERS
//  MEM_TIMEOUT  255  max cycles in WAIT_MEM before abort (1..65535)
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst            in   1   asynchronous, active-low reset
//  in_valid       in   1   memory stage presents an instruction
//  in_ready       out  1   unit can accept this cycle
//  in_rd          in   5   destination register index
//  in_wb_en       in   1   instruction writes rd
//  in_is_load     in   1   result comes from data memory
//  in_funct3      in   3   load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  in_result      in   32  ALU result (non-load) / byte address (load)
//  dmem_rvalid    in   1   data-memory read data valid (single-cycle pulse)
//  dmem_rdata     in   32  word-aligned read data
//  reg_write      out  1   write strobe to register bank
//  rd             out  5   write index to register bank
//  rd_value       out  32  write data to register bank
//  load_err       out  1   1-cycle pulse: misaligned or illegal load, or timeout
//  retired        out  32  count of completed instructions, wraps at 2^32
// BEHAVIOUR
//  States: IDLE, WAIT_MEM. All outputs are registered.
//  Reset values:
//   - state = IDLE; reg_write, load_err = 0; rd = 0; rd_value = 0; retired = 0; timeout counter = 0.
//  in_ready = (state == IDLE). Accept = in_valid & in_ready.
//  Non-load accept:
//   - Next cycle: reg_write = in_wb_en & (in_rd != 0), rd = in_rd, rd_value = in_result.
//   - retired increments; state stays IDLE. Latency 1 cycle, one instruction per cycle.
//  Load accept, legal and aligned -> WAIT_MEM:
//   - Latch rd, wb_en, funct3 and addr[1:0]; clear the timeout counter.
//  Load accept, misaligned or illegal -> no write, no retire increment, state stays IDLE:
//   - Misaligned: LH/LHU with addr[0] = 1; LW with addr[1:0] != 0.
//   - Illegal: funct3 011, 110 or 111.
//   - Next cycle: load_err = 1.
//  WAIT_MEM:
//   - On dmem_rvalid, select by addr[1:0]: byte at bits [8*a+7:8*a]; half at [16*a1+15:16*a1].
//   - Sign-extend for LB/LH; zero-extend for LBU/LHU; LW passes the word.
//   - Next cycle: write as for non-load, retired += 1, state -> IDLE.
//  Timeout:
//   - Counter increments each WAIT_MEM cycle without rvalid.
//   - When it reaches MEM_TIMEOUT: load_err pulse, no write, no retire, state -> IDLE.
//   - rvalid on the same cycle as the limit wins; the load completes normally.
//  Pulse widths:
//   - reg_write and load_err are never held; each is cleared the cycle after it asserts
//     unless a new event sets it.
//  Ignored inputs:
//   - dmem_rvalid outside WAIT_MEM (stale or late response).
//   - in_* while in_ready = 0; the memory stage must hold them stable.
//  in_rd = 0 with in_wb_en = 1: no reg_write, but the instruction retires.
//  Reset mid-WAIT_MEM: aborts to IDLE; a response arriving after reset release is ignored.
// TESTING
//  1. ALU op: rd=5, result 0xDEADBEEF, wb_en=1 -> next cycle reg_write=1, rd=5,
//     rd_value=0xDEADBEEF; retired=1.
//  2. LB at addr 0x103, rdata=0x80_00_00_00 returned 3 cycles later ->
//     rd_value=0xFFFFFF80; LBU at the same address -> 0x00000080.
//  3. LH at addr 0x101 -> load_err pulse 1 cycle after accept; no reg_write; retired unchanged;
//     in_ready stays 1.
//  4. LW, no rvalid for MEM_TIMEOUT=4 cycles -> load_err pulse, return to IDLE;
//     a late rvalid causes no write.
//  5. Back-to-back ALU ops to rd=0 then rd=7 -> no strobe for rd=0, strobe for rd=7;
//     retired +2.
//  6. Assert rst low during WAIT_MEM -> all outputs 0 asynchronously; rvalid after release
//     is ignored.

Source files
------------

// File: rtl/writeback_unit_if.sv
// -----------------------------------------------------------------------------
// writeback_unit_if
// Bundles the signals of the writeback stage:
//   - retire handshake from the memory stage (in_valid/in_ready plus payload)
//   - data-memory read response (dmem_rvalid/dmem_rdata)
//   - register-bank write port and status outputs (reg_write/rd/rd_value,
//     load_err, retired)
// Modports:
//   slave  : the writeback unit itself
//   master : whatever drives the stage (memory stage / data memory / bench)
// -----------------------------------------------------------------------------
interface writeback_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_wb_en;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [31:0] in_result;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] rd_value;
    logic        load_err;
    logic [31:0] retired;

    modport slave (
        input  in_valid, in_rd, in_wb_en, in_is_load, in_funct3, in_result,
        input  dmem_rvalid, dmem_rdata,
        output in_ready, reg_write, rd, rd_value, load_err, retired
    );

    modport master (
        output in_valid, in_rd, in_wb_en, in_is_load, in_funct3, in_result,
        output dmem_rvalid, dmem_rdata,
        input  in_ready, reg_write, rd, rd_value, load_err, retired
    );
endinterface

// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
// Final RV32 pipeline stage feeding the register-bank write port. Accepts one
// retiring instruction per handshake; ALU results are written the next cycle,
// loads wait for the data-memory response, then are aligned and extended.
// Misaligned/illegal loads and memory timeouts raise a one-cycle load_err.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-low reset
//   wb   : writeback_unit_if.slave (handshake, dmem response, write port,
//          load_err pulse, retired counter)
// Parameter:
//   MEM_TIMEOUT : WAIT_MEM cycles without a response before the load aborts
// -----------------------------------------------------------------------------
module writeback_unit #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    writeback_unit_if.slave  wb
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;

    // Counter value of the last WAIT_MEM cycle still allowed to see rvalid.
    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic        ld_wb_en_q, ld_wb_en_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [1:0]  ld_addr_q, ld_addr_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] rd_value_q, rd_value_d;
    logic        load_err_q, load_err_d;
    logic [31:0] retired_q, retired_d;

    // Unsupported funct3 codes, or a half/word access off its natural boundary.
    function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] a);
        logic illegal;
        logic misaligned;
        illegal    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        misaligned = ((f3[1:0] == 2'b01) && a[0]) || ((f3 == 3'b010) && (a != 2'b00));
        return illegal || misaligned;
    endfunction

    // Pick the addressed byte/half out of the word and extend it.
    function automatic logic [31:0] align_load(input logic [2:0] f3,
                                                input logic [1:0] a,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ld_rd_d     = ld_rd_q;
        ld_wb_en_d  = ld_wb_en_q;
        ld_f3_d     = ld_f3_q;
        ld_addr_d   = ld_addr_q;
        reg_write_d = 1'b0;
        load_err_d  = 1'b0;
        rd_d        = rd_q;
        rd_value_d  = rd_value_q;
        retired_d   = retired_q;

        case (state_q)
            IDLE: begin
                if (wb.in_valid) begin
                    if (!wb.in_is_load) begin
                        reg_write_d = wb.in_wb_en && (wb.in_rd != 5'd0);
                        rd_d        = wb.in_rd;
                        rd_value_d  = wb.in_result;
                        retired_d   = retired_q + 32'd1;
                    end else if (load_bad(wb.in_funct3, wb.in_result[1:0])) begin
                        load_err_d = 1'b1;
                    end else begin
                        state_d    = WAIT_MEM;
                        cnt_d      = 16'd0;
                        ld_rd_d    = wb.in_rd;
                        ld_wb_en_d = wb.in_wb_en;
                        ld_f3_d    = wb.in_funct3;
                        ld_addr_d  = wb.in_result[1:0];
                    end
                end
            end
            WAIT_MEM: begin
                // A response in the limit cycle still completes the load.
                if (wb.dmem_rvalid) begin
                    reg_write_d = ld_wb_en_q && (ld_rd_q != 5'd0);
                    rd_d        = ld_rd_q;
                    rd_value_d  = align_load(ld_f3_q, ld_addr_q, wb.dmem_rdata);
                    retired_d   = retired_q + 32'd1;
                    state_d     = IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    load_err_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            ld_rd_q     <= 5'd0;
            ld_wb_en_q  <= 1'b0;
            ld_f3_q     <= 3'd0;
            ld_addr_q   <= 2'd0;
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            rd_value_q  <= 32'd0;
            load_err_q  <= 1'b0;
            retired_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ld_rd_q     <= ld_rd_d;
            ld_wb_en_q  <= ld_wb_en_d;
            ld_f3_q     <= ld_f3_d;
            ld_addr_q   <= ld_addr_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            rd_value_q  <= rd_value_d;
            load_err_q  <= load_err_d;
            retired_q   <= retired_d;
        end
    end

    assign wb.in_ready  = (state_q == IDLE);
    assign wb.reg_write = reg_write_q;
    assign wb.rd        = rd_q;
    assign wb.rd_value  = rd_value_q;
    assign wb.load_err  = load_err_q;
    assign wb.retired   = retired_q;
endmodule

// File: tb/tb_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_unit
// Scoreboard bench for writeback_unit. The driver issues instructions and
// memory responses; for every observable event (write strobe or load_err) it
// pushes the expected outcome computed from the architectural load rules.
// A monitor pops and compares whenever the DUT asserts reg_write or load_err.
// -----------------------------------------------------------------------------
module tb_writeback_unit;
    localparam int T = 4;

    typedef struct {
        bit          is_err;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] ret;
    } exp_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] model_ret = 32'd0;
    exp_t expq[$];

    writeback_unit_if wbif ();

    writeback_unit #(.MEM_TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Reference load result: shift the addressed lane down to bit 0, then extend.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> (8 * a);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic bit model_load_ok(input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            3'b000, 3'b100: return 1'b1;
            3'b001, 3'b101: return (addr % 2) == 0;
            3'b010:         return (addr % 4) == 0;
            default:        return 1'b0;
        endcase
    endfunction

    task automatic push_write(input logic [4:0] r, input logic [31:0] v);
        exp_t e;
        e.is_err = 1'b0; e.rd = r; e.val = v; e.ret = model_ret;
        expq.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1; e.rd = 5'd0; e.val = 32'd0; e.ret = model_ret;
        expq.push_back(e);
    endtask

    task automatic idle_inputs();
        wbif.in_valid    = 1'b0;
        wbif.in_rd       = 5'd0;
        wbif.in_wb_en    = 1'b0;
        wbif.in_is_load  = 1'b0;
        wbif.in_funct3   = 3'd0;
        wbif.in_result   = 32'd0;
        wbif.dmem_rvalid = 1'b0;
        wbif.dmem_rdata  = 32'd0;
    endtask

    task automatic issue_alu(input logic [4:0] r, input logic en, input logic [31:0] res);
        @(negedge clk);
        chk("in_ready_alu", 32'(wbif.in_ready), 32'd1);
        wbif.in_valid   = 1'b1;
        wbif.in_rd      = r;
        wbif.in_wb_en   = en;
        wbif.in_is_load = 1'b0;
        wbif.in_funct3  = 3'($urandom_range(0, 7));
        wbif.in_result  = res;
        model_ret = model_ret + 32'd1;
        if (en && r != 5'd0) push_write(r, res);
        @(posedge clk);
        #1 wbif.in_valid = 1'b0;
    endtask

    // k = cycle index after acceptance in which the response is presented.
    task automatic issue_load(input logic [4:0] r, input logic en, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] rdata, input int k);
        @(negedge clk);
        chk("in_ready_load", 32'(wbif.in_ready), 32'd1);
        wbif.in_valid   = 1'b1;
        wbif.in_rd      = r;
        wbif.in_wb_en   = en;
        wbif.in_is_load = 1'b1;
        wbif.in_funct3  = f3;
        wbif.in_result  = addr;
        if (!model_load_ok(f3, addr)) begin
            push_err();
            @(posedge clk);
            #1 wbif.in_valid = 1'b0;
            // Stray response while idle must be ignored.
            @(negedge clk);
            wbif.dmem_rvalid = 1'b1;
            wbif.dmem_rdata  = $urandom;
            @(posedge clk);
            #1 wbif.dmem_rvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 wbif.in_valid = 1'b0;
        if (k >= T) push_err();
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            if (i < T) chk("in_ready_busy", 32'(wbif.in_ready), 32'd0);
        end
        @(negedge clk);
        wbif.dmem_rvalid = 1'b1;
        wbif.dmem_rdata  = rdata;
        if (k < T) begin
            model_ret = model_ret + 32'd1;
            if (en && r != 5'd0) push_write(r, model_load(f3, addr[1:0], rdata));
        end
        @(posedge clk);
        #1 wbif.dmem_rvalid = 1'b0;
    endtask

    // Monitor: one scoreboard entry per strobe.
    always @(negedge clk) begin
        if (rst && (wbif.reg_write || wbif.load_err)) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event actual=reg_write:%0b,load_err:%0b required=none",
                         wbif.reg_write, wbif.load_err);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("reg_write", 32'(wbif.reg_write), 32'(!e.is_err));
                chk("load_err", 32'(wbif.load_err), 32'(e.is_err));
                if (!e.is_err) begin
                    chk("rd", 32'(wbif.rd), 32'(e.rd));
                    chk("rd_value", wbif.rd_value, e.val);
                end
                chk("retired_evt", wbif.retired, e.ret);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_reg_write"}, 32'(wbif.reg_write), 32'd0);
        chk({tag, "_load_err"}, 32'(wbif.load_err), 32'd0);
        chk({tag, "_rd"}, 32'(wbif.rd), 32'd0);
        chk({tag, "_rd_value"}, wbif.rd_value, 32'd0);
        chk({tag, "_retired"}, wbif.retired, 32'd0);
        chk({tag, "_in_ready"}, 32'(wbif.in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b1;

        // ALU write
        issue_alu(5'd5, 1'b1, 32'hDEADBEEF);
        // LB / LBU at 0x103, response three cycles after acceptance
        issue_load(5'd3, 1'b1, 3'b000, 32'h103, 32'h8000_0000, 2);
        issue_load(5'd4, 1'b1, 3'b100, 32'h103, 32'h8000_0000, 2);
        // Halfword lanes and full word
        issue_load(5'd8, 1'b1, 3'b001, 32'h102, 32'h9234_5678, 0);
        issue_load(5'd9, 1'b1, 3'b101, 32'h102, 32'h9234_5678, 1);
        issue_load(5'd10, 1'b1, 3'b010, 32'h100, 32'hCAFE_F00D, 3);
        // Misaligned LH, then in_ready must still be high
        issue_load(5'd6, 1'b1, 3'b001, 32'h101, 32'h0, 0);
        @(negedge clk);
        chk("in_ready_after_err", 32'(wbif.in_ready), 32'd1);
        // Illegal funct3
        issue_load(5'd6, 1'b1, 3'b111, 32'h100, 32'h0, 0);
        // Timeout, late response ignored; response in the limit cycle still wins
        issue_load(5'd11, 1'b1, 3'b010, 32'h200, 32'h1234_5678, T + 2);
        issue_load(5'd12, 1'b1, 3'b010, 32'h204, 32'h8765_4321, T - 1);
        // rd = 0 retires silently, rd = 7 writes
        issue_alu(5'd0, 1'b1, 32'h1111_1111);
        issue_alu(5'd7, 1'b1, 32'h7777_7777);
        @(negedge clk);
        chk("retired_after_b2b", wbif.retired, model_ret);

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 1) == 0)
                issue_alu(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
            else
                issue_load(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0),
                           3'($urandom_range(0, 7)), $urandom, $urandom,
                           int'($urandom_range(0, T + 2)));
        end
        repeat (2) @(negedge clk);

        // Reset during WAIT_MEM
        @(negedge clk);
        wbif.in_valid   = 1'b1;
        wbif.in_rd      = 5'd13;
        wbif.in_wb_en   = 1'b1;
        wbif.in_is_load = 1'b1;
        wbif.in_funct3  = 3'b010;
        wbif.in_result  = 32'h300;
        @(posedge clk);
        #1 wbif.in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_pre_rst", 32'(wbif.in_ready), 32'd0);
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        model_ret = 32'd0;
        expq.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wbif.dmem_rvalid = 1'b1;
        wbif.dmem_rdata  = 32'hABCD_EF01;
        @(posedge clk);
        #1 wbif.dmem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("retired_post_rst", wbif.retired, 32'd0);
        issue_alu(5'd2, 1'b1, 32'h0000_0042);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(expq.size()), 32'd0);
        chk("retired_final", wbif.retired, model_ret);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
